// File: rtl/zclk_pkg.sv
// Shared encodings, FSM state constants and the boost substitution helper for the Z80 clock scheduler.
package zclk_pkg;

   localparam logic [1:0] T35  = 2'b00;
   localparam logic [1:0] T70  = 2'b01;
   localparam logic [1:0] T140 = 2'b10;

   localparam int SETTLE_DEF = 2;

   typedef logic [1:0] zstate_t;

   localparam zstate_t ST_IDLE   = 2'd0;
   localparam zstate_t ST_ARMED  = 2'd1;
   localparam zstate_t ST_SWITCH = 2'd2;
   localparam zstate_t ST_SETTLE = 2'd3;

   // Boost lifts a 3.5 MHz request to 7 MHz; faster requests pass through unchanged.
   function automatic logic [1:0] eff_turbo(input logic boost, input logic [1:0] req);
      return (boost && (req == T35)) ? T70 : req;
   endfunction

endpackage

// File: rtl/zclk_rr_arb.sv
// Round-robin arbiter: combinational grant of the lowest active index at or above the pointer.
// The pointer moves past the granted index only when adv_i confirms the grant was taken.
module zclk_rr_arb
   import zclk_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [NREQ-1:0] req_i,
   input  logic            adv_i,
   output logic [IW-1:0]   gnt_idx_o,
   output logic            gnt_vld_o
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;

   // Scan offsets from the far end so the smallest offset from the pointer wins.
   always_comb begin
      int j;
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (req_i[j]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = j[IW-1:0];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv_i && gnt_vld_o) begin
         if (int'(gnt_idx_o) == NREQ - 1) begin
            ptr_d = '0;
         end else begin
            ptr_d = gnt_idx_o + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/zclk_sched.sv
// Z80 clock scheduler: applies turbo changes on an RFSH zpos and merges requester wait states into cpu_stall.
// Optional boost input is compiled in with ZCLK_BOOST_EN.
module zclk_sched
   import zclk_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int LENW   = 4,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 zpos,
   input  logic                 zneg,
   input  logic                 rfsh_s,
`ifdef ZCLK_BOOST_EN
   input  logic                 boost,
`endif
   input  logic [1:0]           turbo_req,
   output logic [1:0]           turbo,
   input  logic [NREQ-1:0]      stall_req,
   input  logic [NREQ*LENW-1:0] stall_len,
   output logic [NREQ-1:0]      stall_ack,
   output logic                 cpu_stall,
   output logic                 switching
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

   zstate_t         state_q, state_d;
   logic [1:0]      turbo_q, turbo_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [LENW-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            stall_q;
   logic [1:0]      req_eff;
   logic            sw_go;
   logic            arb_en;
   logic            grant;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_vld;
   logic            unused_zneg;

   assign unused_zneg = zneg;

`ifdef ZCLK_BOOST_EN
   assign req_eff = eff_turbo(boost, turbo_req);
`else
   assign req_eff = turbo_req;
`endif

   always_comb begin
      state_d  = state_q;
      turbo_d  = turbo_q;
      settle_d = settle_q;
      sw_go    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_eff != turbo_q) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (req_eff == turbo_q) begin
               state_d = ST_IDLE;
            end else if (rfsh_s && zpos && (cnt_q == '0)) begin
               state_d = ST_SWITCH;
               sw_go   = 1'b1;
            end
         end
         ST_SWITCH: begin
            turbo_d  = req_eff;
            settle_d = SW'(SETTLE);
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q <= SW'(1)) begin
               settle_d = '0;
               state_d  = ST_IDLE;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Granting while the counter is on its last cycle keeps back-to-back stalls gap-free.
   assign arb_en = ((state_q == ST_IDLE) || (state_q == ST_ARMED)) && !sw_go && (cnt_q <= LENW'(1));
   assign grant  = arb_en && gnt_vld;

   // A requester still shows its request during its own ack cycle; masking avoids a double grant.
   zclk_rr_arb #(
      .NREQ(NREQ)
   ) u_arb (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (stall_req & ~ack_q),
      .adv_i    (grant),
      .gnt_idx_o(gnt_idx),
      .gnt_vld_o(gnt_vld)
   );

   always_comb begin
      cnt_d = cnt_q;
      ack_d = '0;
      if (grant) begin
         cnt_d = stall_len[int'(gnt_idx)*LENW +: LENW];
         ack_d = NREQ'(1) << gnt_idx;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         turbo_q  <= T35;
         settle_q <= '0;
         cnt_q    <= '0;
         ack_q    <= '0;
         stall_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         turbo_q  <= turbo_d;
         settle_q <= settle_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         stall_q  <= (cnt_q != '0);
      end
   end

   assign turbo     = turbo_q;
   assign stall_ack = ack_q;
   assign cpu_stall = stall_q || (state_q == ST_SWITCH) || (state_q == ST_SETTLE);
   assign switching = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zclk_sched.sv
// Directed bench for zclk_sched: turbo switching, stall arbitration and their interaction.
module tb_zclk_sched;
   import zclk_pkg::*;

   localparam int NREQ = 4;
   localparam int LENW = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 zpos = 1'b0;
   logic                 zneg = 1'b0;
   logic                 rfsh_s = 1'b0;
   logic [1:0]           turbo_req = T35;
   logic [1:0]           turbo;
   logic [NREQ-1:0]      stall_req = '0;
   logic [NREQ*LENW-1:0] stall_len = '0;
   logic [NREQ-1:0]      stall_ack;
   logic                 cpu_stall;
   logic                 switching;
`ifdef ZCLK_BOOST_EN
   logic                 boost = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   zclk_sched #(.NREQ(NREQ), .LENW(LENW), .SETTLE(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .zpos     (zpos),
      .zneg     (zneg),
      .rfsh_s   (rfsh_s),
`ifdef ZCLK_BOOST_EN
      .boost    (boost),
`endif
      .turbo_req(turbo_req),
      .turbo    (turbo),
      .stall_req(stall_req),
      .stall_len(stall_len),
      .stall_ack(stall_ack),
      .cpu_stall(cpu_stall),
      .switching(switching)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ack_idx(input logic [NREQ-1:0] a);
      for (int i = 0; i < NREQ; i++) begin
         if (a[i]) return i;
      end
      return 0;
   endfunction

   task automatic test_reset();
      #12;
      checks++; if (turbo !== T35) begin errors++; $display("FAIL reset_turbo: got %b expected %b", turbo, T35); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall: got %b expected 0", cpu_stall); end
      checks++; if (stall_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", stall_ack); end
      checks++; if (switching !== 1'b0) begin errors++; $display("FAIL reset_switching: got %b expected 0", switching); end
      #10 rst = 1'b0;
      tick();
   endtask

   task automatic test_withdraw();
      int s = 0;
      turbo_req = T70;
      tick();
      if (cpu_stall) s++;
      checks++; if (switching !== 1'b1) begin errors++; $display("FAIL withdraw_armed: got %b expected 1", switching); end
      turbo_req = T35;
      tick();
      if (cpu_stall) s++;
      checks++; if (switching !== 1'b0) begin errors++; $display("FAIL withdraw_idle: got %b expected 0", switching); end
      repeat (3) begin
         tick();
         if (cpu_stall) s++;
      end
      checks++; if (turbo !== T35) begin errors++; $display("FAIL withdraw_turbo: got %b expected %b", turbo, T35); end
      checks++; if (s !== 0) begin errors++; $display("FAIL withdraw_stall: got %0d stall cycles expected 0", s); end
   endtask

   task automatic test_switch();
      int s = 0;
      int ack_at = 0;
      stall_len = {4'd0, 4'd3, 4'd3, 4'd3};
      turbo_req = T140;
      repeat (3) tick();
      checks++; if (turbo !== T35) begin errors++; $display("FAIL switch_wait_turbo: got %b expected %b", turbo, T35); end
      checks++; if (switching !== 1'b1) begin errors++; $display("FAIL switch_wait_switching: got %b expected 1", switching); end
      // Requester 3 asks in the same cycle the switch is taken; the switch must win.
      rfsh_s = 1'b1; zpos = 1'b1; stall_req = 4'b1000;
      tick();
      rfsh_s = 1'b0; zpos = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         if (cpu_stall) s++;
         if (stall_ack != '0 && ack_at == 0) ack_at = i;
         stall_req = stall_req & ~stall_ack;
         if (i < 6) tick();
      end
      checks++; if (s !== 3) begin errors++; $display("FAIL switch_stall_len: got %0d expected 3", s); end
      checks++; if (ack_at !== 5) begin errors++; $display("FAIL switch_blocks_grant: ack at cycle %0d expected 5", ack_at); end
      checks++; if (turbo !== T140) begin errors++; $display("FAIL switch_turbo: got %b expected %b", turbo, T140); end
      checks++; if (switching !== 1'b0) begin errors++; $display("FAIL switch_done: got %b expected 0", switching); end
      stall_req = '0;
      repeat (2) tick();
   endtask

   task automatic test_round_robin();
      int n_ack = 0;
      int tot = 0;
      int run = 0;
      int best = 0;
      int bad = 0;
      logic [7:0] order = '0;
      stall_len = {4'd3, 4'd3, 4'd3, 4'd3};
      stall_req = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (stall_ack != '0) begin
            if (!$onehot(stall_ack)) bad++;
            else if (n_ack < 4) order[n_ack*2 +: 2] = 2'(ack_idx(stall_ack));
            n_ack++;
            stall_req = stall_req & ~stall_ack;
         end
         if (cpu_stall) begin
            tot++; run++;
            if (run > best) best = run;
         end else begin
            run = 0;
         end
      end
      checks++; if (n_ack !== 4 || bad !== 0) begin errors++; $display("FAIL rr_ack_count: got %0d acks (%0d not one-hot) expected 4", n_ack, bad); end
      checks++; if (order !== 8'b11_10_01_00) begin errors++; $display("FAIL rr_order: got %b expected 11100100", order); end
      checks++; if (tot !== 12) begin errors++; $display("FAIL rr_stall_total: got %0d expected 12", tot); end
      checks++; if (best !== 12) begin errors++; $display("FAIL rr_stall_contiguous: got %0d expected 12", best); end
   endtask

   task automatic test_ptr_wrap();
      int w = 0;
      stall_req = 4'b1001;
      tick();
      checks++; if (stall_ack !== 4'b0001) begin errors++; $display("FAIL ptr_at_zero: got %b expected 0001", stall_ack); end
      stall_req = 4'b1000;
      do begin tick(); w++; end while (stall_ack == '0 && w < 10);
      checks++; if (stall_ack !== 4'b1000) begin errors++; $display("FAIL ptr_second: got %b expected 1000", stall_ack); end
      stall_req = '0;
      repeat (8) tick();
   endtask

   task automatic test_zero_len();
      int s = 0;
      int a = 0;
      int w = 0;
      stall_len = {4'd3, 4'd2, 4'd0, 4'd3};
      stall_req = 4'b0010;
      tick();
      checks++; if (stall_ack !== 4'b0010) begin errors++; $display("FAIL zero_ack: got %b expected 0010", stall_ack); end
      stall_req = '0;
      repeat (4) begin
         tick();
         if (cpu_stall) s++;
         if (stall_ack != '0) a++;
      end
      checks++; if (s !== 0) begin errors++; $display("FAIL zero_no_stall: got %0d stall cycles expected 0", s); end
      checks++; if (a !== 0) begin errors++; $display("FAIL zero_single_ack: got %0d extra acks expected 0", a); end
      stall_req = 4'b0110;
      tick();
      checks++; if (stall_ack !== 4'b0100) begin errors++; $display("FAIL zero_next_is_2: got %b expected 0100", stall_ack); end
      stall_req = 4'b0010;
      do begin tick(); w++; end while (stall_ack == '0 && w < 10);
      checks++; if (stall_ack !== 4'b0010) begin errors++; $display("FAIL zero_then_1: got %b expected 0010", stall_ack); end
      stall_req = '0;
      repeat (6) tick();
   endtask

   task automatic test_deferred();
      int s = 0;
      stall_len = {4'd3, 4'd5, 4'd0, 4'd3};
      stall_req = 4'b0100;
      tick();
      checks++; if (stall_ack !== 4'b0100) begin errors++; $display("FAIL defer_ack: got %b expected 0100", stall_ack); end
      for (int i = 1; i <= 12; i++) begin
         if (cpu_stall) s++;
         if (i == 1) begin
            stall_req = '0;
            turbo_req = T70;
         end
         // RFSH zpos while the stall runs, later RFSH without zpos: neither may switch.
         rfsh_s = (i == 2) || (i == 9);
         zpos   = (i == 2);
         tick();
      end
      rfsh_s = 1'b0; zpos = 1'b0;
      checks++; if (s !== 5) begin errors++; $display("FAIL defer_stall_intact: got %0d expected 5", s); end
      checks++; if (turbo !== T140) begin errors++; $display("FAIL defer_turbo_held: got %b expected %b", turbo, T140); end
      checks++; if (switching !== 1'b1) begin errors++; $display("FAIL defer_still_armed: got %b expected 1", switching); end
      rfsh_s = 1'b1; zpos = 1'b1;
      tick();
      rfsh_s = 1'b0; zpos = 1'b0;
      repeat (4) tick();
      checks++; if (turbo !== T70) begin errors++; $display("FAIL defer_turbo_applied: got %b expected %b", turbo, T70); end
      checks++; if (switching !== 1'b0) begin errors++; $display("FAIL defer_done: got %b expected 0", switching); end
   endtask

   task automatic test_reset_mid_settle();
      turbo_req = T140;
      tick();
      rfsh_s = 1'b1; zpos = 1'b1;
      tick();
      rfsh_s = 1'b0; zpos = 1'b0;
      tick();
      checks++; if (cpu_stall !== 1'b1 || turbo !== T140) begin errors++; $display("FAIL settle_pre: got stall=%b turbo=%b expected stall=1 turbo=%b", cpu_stall, turbo, T140); end
      #2 rst = 1'b1;
      #1;
      checks++; if (turbo !== T35) begin errors++; $display("FAIL arst_turbo: got %b expected %b", turbo, T35); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL arst_cpu_stall: got %b expected 0", cpu_stall); end
      checks++; if (switching !== 1'b0) begin errors++; $display("FAIL arst_switching: got %b expected 0", switching); end
      checks++; if (stall_ack !== 4'b0000) begin errors++; $display("FAIL arst_ack: got %b expected 0000", stall_ack); end
      turbo_req = T35;
      #2 rst = 1'b0;
      tick();
      checks++; if (turbo !== T35 || switching !== 1'b0) begin errors++; $display("FAIL arst_after: got turbo=%b switching=%b expected %b 0", turbo, switching, T35); end
   endtask

   initial begin
      test_reset();
      test_withdraw();
      test_switch();
      test_round_robin();
      test_ptr_wrap();
      test_zero_len();
      test_deferred();
      test_reset_mid_settle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
